// File: rtl/pc_fetch_controller.sv
// PC sequencer and single-outstanding instruction fetch front end.
// Stale responses after a redirect are drained before refetching.
module pc_fetch_controller #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INSTR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  pc_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t state;
  state_t nxt_run;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] rpc;
  logic [ADDR_W-1:0] pc_inc;

  assign rpc = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign pc_inc = pc + ADDR_W'(4);
  assign nxt_run = en ? S_REQ : S_IDLE;

  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr = pc;
  assign pc_out = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      pc <= RESET_VECTOR;
      if_valid <= 1'b0;
      if_pc <= '0;
      if_instr <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (redirect_valid) pc <= rpc;
          else if (en) state <= S_REQ;
        end
        S_REQ: begin
          if (redirect_valid) pc <= rpc;
          if (imem_req_ready)
            state <= redirect_valid ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          if (redirect_valid) begin
            pc <= rpc;
            state <= imem_rsp_valid ? nxt_run : S_DRAIN;
          end else if (imem_rsp_valid) begin
            if_instr <= imem_rsp_data;
            if_pc <= pc;
            if_valid <= 1'b1;
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          // redirect wins over acceptance of the held word
          if (redirect_valid) begin
            pc <= rpc;
            if_valid <= 1'b0;
            state <= nxt_run;
          end else if (if_ready) begin
            pc <= pc_inc;
            if_valid <= 1'b0;
            state <= nxt_run;
          end
        end
        S_DRAIN: begin
          if (redirect_valid) pc <= rpc;
          if (imem_rsp_valid) state <= nxt_run;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pc_fetch_controller.md
Name: pc_fetch_controller

Overview:
- Sequences the program counter and fetches instructions from instruction memory.
- Holds the architectural fetch PC, issues one outstanding request at a time over a valid/ready request channel, and accepts the returned word.
- Presents the instruction and its PC to decode with a valid/ready handshake.
- Handles redirects (branch/jump) by discarding stale in-flight responses.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, PC/address width
INSTR_W, 32, instruction word width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
en  in  1  run enable; 0 = stop issuing new fetches
redirect_valid  in  1  load redirect_pc this cycle
redirect_pc  in  ADDR_W  redirect target
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  fetch address
imem_rsp_valid  in  1  response word valid (exactly one per accepted request, latency >= 1 cycle)
imem_rsp_data  in  INSTR_W  response word
if_valid  out  1  instruction available to decode
if_ready  in  1  decode accepts instruction
if_pc  out  ADDR_W  PC of presented instruction
if_instr  out  INSTR_W  presented instruction
pc_out  out  ADDR_W  current fetch PC

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, pc=RESET_VECTOR.
  - imem_req_valid=0, if_valid=0, if_pc=0, if_instr=0.
  - All pending transactions are forgotten. A response arriving after reset deassertion while in IDLE is ignored.
- pc_out=pc at all times. imem_req_addr=pc.
- redirect_pc[1:0] is forced to 2'b00 when loaded.
- PC increment is pc+4 modulo 2^ADDR_W: 0xFFFF_FFFC -> 0x0000_0000.
- States:
  - IDLE: no request. redirect_valid loads pc and stays in IDLE. en=1 -> REQ next cycle.
  - REQ: imem_req_valid=1.
    - redirect_valid without handshake: pc<=redirect_pc, stay REQ. This is the only case where the address may change while valid is high.
    - imem_req_valid&imem_req_ready: -> WAIT. If redirect_valid is asserted in the same cycle, pc<=redirect_pc and -> DRAIN.
    - en=0 does not retract a pending request.
  - WAIT: imem_req_valid=0.
    - imem_rsp_valid: capture if_instr<=imem_rsp_data, if_pc<=pc -> HOLD.
    - redirect_valid (with or without imem_rsp_valid): pc<=redirect_pc. Without a response -> DRAIN. If the response arrives in the same cycle it is discarded -> REQ if en, else IDLE.
  - HOLD: if_valid=1; if_pc and if_instr stay stable until accepted.
    - if_ready: pc<=pc+4 -> REQ if en, else IDLE.
    - redirect_valid (priority over if_ready): if_valid drops next cycle, pc<=redirect_pc -> REQ if en, else IDLE.
  - DRAIN: imem_req_valid=0, if_valid=0. Waits for the stale response and discards it.
    - On imem_rsp_valid -> REQ if en, else IDLE.
    - A further redirect_valid here only reloads pc.
- Throughput and latency:
  - Best case is one instruction per 3 cycles: REQ->WAIT->HOLD with 1-cycle memory and if_ready=1.
  - Request-to-if_valid latency = memory latency + 1 register stage.
- Redirect priority over increment in every state. At most one outstanding request ever.
- Outputs are registered except imem_req_valid/addr, which decode from state/pc.

Test Plan:
- Reset release, en=1, 1-cycle memory returning addr^32'hA5A5_0000, if_ready=1 -> requests at 0x0, 0x4, 0x8. if_pc/if_instr pairs: (0x0, 0xA5A5_0000), (0x4, 0xA5A5_0004), (0x8, 0xA5A5_0008). Every 3rd cycle if_valid=1.
- imem_req_ready low 4 cycles in REQ -> imem_req_valid stays 1 and imem_req_addr stable at 0x8; no if_valid.
- Redirect to 0x103 in WAIT with 3-cycle memory -> stale word for 0x8 never appears on if_*. Next request addr 0x100, if_pc=0x100.
- if_ready=0 for 5 cycles in HOLD -> if_valid, if_pc, if_instr held. pc_out unchanged. Then if_ready=1 -> pc_out increments by 4.
- Redirect to 0xFFFF_FFFC, run 2 fetches -> if_pc 0xFFFF_FFFC then 0x0000_0000.
- rst asserted mid-WAIT, response arrives 1 cycle after release with en=0 -> state IDLE, if_valid=0, pc_out=RESET_VECTOR, response ignored.
